memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access_if.sv | 49 ++++
 rtl/memory_access.sv | 142 ++++++++++++++
 tb/tb_memory_access.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_if.sv
// Execute-to-memory stage bundle: E-stage fields in, data bus, and M-stage results out.
// slave is the memory stage itself; master is whoever drives the E-stage and the data bus.
interface memory_access_if;
   logic [31:0] alu_result_e_i;
   logic [31:0] write_data_e_i;
   logic [4:0]  rd_e_i;
   logic [31:0] pc_plus_4_e_i;
   logic [1:0]  result_src_e_i;
   logic        valid_e_i;
   logic        reg_write_e_i;
   logic        mem_read_e_i;
   logic        mem_write_e_i;
   logic [2:0]  funct3_e_i;
   logic        flush_m_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_ready_i;
   logic [31:0] dmem_rdata_i;
   logic [31:0] alu_result_m_o;
   logic [31:0] read_data_m_o;
   logic [31:0] pc_plus_4_m_o;
   logic [4:0]  rd_m_o;
   logic [1:0]  result_src_m_o;
   logic        reg_write_m_o;
   logic        stall_m_o;
   logic        access_err_o;
   logic        timeout_o;

   modport slave (
      input  alu_result_e_i, write_data_e_i, rd_e_i, pc_plus_4_e_i, result_src_e_i,
      input  valid_e_i, reg_write_e_i, mem_read_e_i, mem_write_e_i, funct3_e_i, flush_m_i,
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
      input  dmem_ready_i, dmem_rdata_i,
      output alu_result_m_o, read_data_m_o, pc_plus_4_m_o, rd_m_o, result_src_m_o,
      output reg_write_m_o, stall_m_o, access_err_o, timeout_o
   );

   modport master (
      output alu_result_e_i, write_data_e_i, rd_e_i, pc_plus_4_e_i, result_src_e_i,
      output valid_e_i, reg_write_e_i, mem_read_e_i, mem_write_e_i, funct3_e_i, flush_m_i,
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
      output dmem_ready_i, dmem_rdata_i,
      input  alu_result_m_o, read_data_m_o, pc_plus_4_m_o, rd_m_o, result_src_m_o,
      input  reg_write_m_o, stall_m_o, access_err_o, timeout_o
   );
endinterface

// File: rtl/memory_access.sv
// Memory stage: one E->M register, data-bus access with byte lanes and load extension; 1 cycle plus bus waits.
// A pending access stalls upstream until dmem_ready_i; a wait of TIMEOUT_CYCLES aborts and sets sticky timeout_o.
module memory_access #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic            clk_i,
   input logic            reset_i,
   memory_access_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

   typedef struct packed {
      logic        valid;
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] pc4;
      logic [1:0]  rsrc;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic [2:0]  funct3;
   } em_reg_t;

   em_reg_t     em_q;
   logic [0:0]  state_q;
   logic [7:0]  cnt_q;
   logic        timeout_q;

   logic [1:0]  sz;
   logic [1:0]  off;
   logic        is_store, is_load, mem_op, illegal, misal, legal_op;
   logic        abort, req, stall;
   logic [31:0] lane;
   logic [31:0] ext;
   logic [3:0]  be;
   logic [31:0] wdata;

   assign sz       = em_q.funct3[1:0];
   assign off      = em_q.alu[1:0];
   // Read and write both set is treated as a store.
   assign is_store = em_q.mem_write;
   assign is_load  = em_q.mem_read & ~em_q.mem_write;
   assign mem_op   = em_q.valid & (em_q.mem_read | em_q.mem_write);
   assign illegal  = (sz == 2'b11) | (em_q.funct3[2] & (is_store | (sz == 2'b10)));
   assign misal    = ((sz == 2'b01) & off[0]) | ((sz == 2'b10) & (off != 2'b00));
   assign legal_op = mem_op & ~illegal & ~misal;

   assign abort = (state_q == WAIT) & (cnt_q == TO_LIM) & ~bus.dmem_ready_i;
   assign req   = legal_op & ~abort;
   assign stall = req & ~bus.dmem_ready_i;

   always_comb begin
      be    = 4'b1111;
      wdata = em_q.wdata;
      case (sz)
         2'b00: begin
            be    = 4'b0001 << off;
            wdata = {4{em_q.wdata[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << off;
            wdata = {2{em_q.wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign lane = bus.dmem_rdata_i >> {off, 3'b000};

   always_comb begin
      ext = lane;
      case (sz)
         2'b00:   ext = em_q.funct3[2] ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
         2'b01:   ext = em_q.funct3[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: ext = lane;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         em_q <= '0;
      end else if (!stall) begin
         em_q.valid     <= bus.valid_e_i & ~bus.flush_m_i;
         em_q.alu       <= bus.alu_result_e_i;
         em_q.wdata     <= bus.write_data_e_i;
         em_q.rd        <= bus.rd_e_i;
         em_q.pc4       <= bus.pc_plus_4_e_i;
         em_q.rsrc      <= bus.result_src_e_i;
         em_q.reg_write <= bus.reg_write_e_i;
         em_q.mem_read  <= bus.mem_read_e_i;
         em_q.mem_write <= bus.mem_write_e_i;
         em_q.funct3    <= bus.funct3_e_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (abort) timeout_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (stall) begin
                  state_q <= WAIT;
                  cnt_q   <= 8'd1;
               end
            end
            default: begin
               if (bus.dmem_ready_i || abort) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
         endcase
      end
   end

   // Bus fields are driven only for a legal access so they sit at zero otherwise.
   assign bus.dmem_req_o     = req;
   assign bus.dmem_we_o      = req & is_store;
   assign bus.dmem_addr_o    = legal_op ? {em_q.alu[31:2], 2'b00} : 32'd0;
   assign bus.dmem_be_o      = legal_op ? be : 4'd0;
   assign bus.dmem_wdata_o   = legal_op ? wdata : 32'd0;

   assign bus.stall_m_o      = stall;
   assign bus.access_err_o   = mem_op & (illegal | misal);
   assign bus.timeout_o      = timeout_q;
   assign bus.reg_write_m_o  = em_q.valid & em_q.reg_write & ~stall & ~(illegal | misal) & ~abort
                               | (em_q.valid & em_q.reg_write & ~mem_op & ~stall);
   assign bus.rd_m_o         = stall ? 5'd0 : em_q.rd;
   assign bus.alu_result_m_o = em_q.alu;
   assign bus.pc_plus_4_m_o  = em_q.pc4;
   assign bus.result_src_m_o = em_q.rsrc;
   assign bus.read_data_m_o  = (req & is_load & bus.dmem_ready_i) ? ext : 32'd0;
endmodule

// File: tb/tb_memory_access.sv
// Scoreboarded bench for memory_access: driver pushes model predictions, monitor pops on each retiring cycle.
module tb_memory_access;
   localparam int TO    = 4;
   localparam int NRAND = 400;

   logic clk_i = 1'b0;
   logic reset_i;
   memory_access_if ma_if ();

   memory_access #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .bus    (ma_if)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit        valid, rw, mr, mw;
      bit [2:0]  f3;
      bit [31:0] alu, wd, pc, rdata;
      bit [4:0]  rd;
      bit [1:0]  rs;
      int        waits;
   } ins_t;

   typedef struct {
      bit        live, err, mem, store, abort, rw;
      int        stalls, waits;
      bit [31:0] addr, wdata, rdv, alu, pc, rdata;
      bit [3:0]  be;
      bit [4:0]  rd;
      bit [1:0]  rs;
   } exp_t;

   exp_t  exp_q[$];
   ins_t  dir_q[$];
   exp_t  head;
   int    n_chk = 0;
   int    n_err = 0;
   int    scnt = 0;
   bit    to_exp = 0;
   bit    mon_en = 0;
   logic  mon_ready = 0, man_ready = 0;
   logic [31:0] mon_rdata = '0, man_rdata = '0;

   assign ma_if.dmem_ready_i = mon_en ? mon_ready : man_ready;
   assign ma_if.dmem_rdata_i = mon_en ? mon_rdata : man_rdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: access width in bytes, lane offset, and plain shift/mask arithmetic.
   function automatic exp_t model(input ins_t i);
      exp_t e;
      int n, off;
      bit legal;
      logic [63:0] v, m;
      e = '{default: 0};
      e.live = i.valid; e.rd = i.rd; e.alu = i.alu; e.pc = i.pc; e.rs = i.rs;
      e.waits = i.waits; e.rdata = i.rdata;
      if (i.valid && (i.mr || i.mw)) begin
         case (i.f3[1:0])
            2'd0: n = 1;
            2'd1: n = 2;
            2'd2: n = 4;
            default: n = 0;
         endcase
         legal = (n != 0) && !(i.f3[2] && (i.mw || n == 4));
         off = int'(i.alu[1:0]);
         if (!legal || (off % n) != 0) begin
            e.err = 1;
         end else begin
            e.mem = 1; e.store = i.mw;
            e.addr = i.alu - 32'(off);
            e.be = 4'(((1 << n) - 1) << off);
            for (int b = 0; b < 4; b++) e.wdata[8*b +: 8] = i.wd[8*(b % n) +: 8];
            e.abort = i.waits > TO;
            e.stalls = e.abort ? TO : i.waits;
            if (!i.mw && !e.abort) begin
               v = 64'(i.rdata) >> (8 * off);
               m = (64'd1 << (8 * n)) - 64'd1;
               v = v & m;
               if (!i.f3[2] && v[8*n-1]) v = v | ~m;
               e.rdv = v[31:0];
            end
         end
      end
      e.rw = i.valid && i.rw && !e.err && !e.abort;
      return e;
   endfunction

   function automatic ins_t mk(input bit mr, input bit mw, input bit rw, input bit [2:0] f3,
                               input bit [31:0] alu, input bit [31:0] wd, input int waits,
                               input bit [31:0] rdata);
      ins_t i;
      i = '{default: 0};
      i.valid = 1; i.mr = mr; i.mw = mw; i.rw = rw; i.f3 = f3; i.alu = alu; i.wd = wd;
      i.waits = waits; i.rdata = rdata; i.rd = 5'd5; i.pc = alu + 32'd4; i.rs = 2'd1;
      return i;
   endfunction

   function automatic ins_t rand_ins();
      ins_t i;
      int k, r;
      bit [2:0] legal_f3[5];
      legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      k = $urandom_range(0, 3);
      i.valid = $urandom_range(0, 9) != 0;
      i.mr = (k == 1) || (k == 3);
      i.mw = (k == 2) || (k == 3);
      i.rw = 1'($urandom());
      i.f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom());
      i.alu = ($urandom() & 32'h0000_0FFC) | 32'($urandom_range(0, 3));
      i.wd = $urandom(); i.pc = $urandom(); i.rdata = $urandom();
      i.rd = 5'($urandom()); i.rs = 2'($urandom());
      r = $urandom_range(0, 19);
      i.waits = (r < 8) ? 0 : (r < 16) ? $urandom_range(1, 3) : (r < 18) ? TO : 9;
      return i;
   endfunction

   task automatic drive(input ins_t i, input bit flush);
      ma_if.valid_e_i = i.valid; ma_if.reg_write_e_i = i.rw;
      ma_if.mem_read_e_i = i.mr; ma_if.mem_write_e_i = i.mw;
      ma_if.funct3_e_i = i.f3; ma_if.alu_result_e_i = i.alu;
      ma_if.write_data_e_i = i.wd; ma_if.pc_plus_4_e_i = i.pc;
      ma_if.rd_e_i = i.rd; ma_if.result_src_e_i = i.rs;
      ma_if.flush_m_i = flush;
   endtask

   // Monitor and bus responder: head of queue is always what sits in the M register.
   always @(negedge clk_i) begin
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL queue_empty: got 0 entries expected at least 1");
         end else begin
            bit exp_stall, exp_req;
            head = exp_q[0];
            exp_stall = head.mem && (scnt < head.stalls);
            exp_req   = head.mem && (exp_stall || !head.abort);
            mon_ready = head.mem && (scnt == head.waits);
            mon_rdata = mon_ready ? head.rdata : $urandom();
            #1;
            chk("timeout", 32'(ma_if.timeout_o), 32'(to_exp));
            chk("stall", 32'(ma_if.stall_m_o), 32'(exp_stall));
            chk("req", 32'(ma_if.dmem_req_o), 32'(exp_req));
            chk("access_err", 32'(ma_if.access_err_o), 32'(head.err));
            if (exp_req) begin
               chk("we", 32'(ma_if.dmem_we_o), 32'(head.store));
               chk("addr", ma_if.dmem_addr_o, head.addr);
               chk("be", 32'(ma_if.dmem_be_o), 32'(head.be));
               if (head.store) chk("wdata", ma_if.dmem_wdata_o, head.wdata);
            end
            if (exp_stall) begin
               chk("stall_reg_write", 32'(ma_if.reg_write_m_o), 32'd0);
               chk("stall_rd", 32'(ma_if.rd_m_o), 32'd0);
               scnt++;
            end else begin
               chk("reg_write", 32'(ma_if.reg_write_m_o), 32'(head.rw));
               chk("read_data", ma_if.read_data_m_o, head.rdv);
               if (head.live) begin
                  chk("rd", 32'(ma_if.rd_m_o), 32'(head.rd));
                  chk("alu", ma_if.alu_result_m_o, head.alu);
                  chk("pc4", ma_if.pc_plus_4_m_o, head.pc);
                  chk("rsrc", 32'(ma_if.result_src_m_o), 32'(head.rs));
               end
               if (head.abort) to_exp = 1;
               void'(exp_q.pop_front());
               scnt = 0;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      ins_t cur, mi, bub;
      int issued, total, guard;
      bit flush;
      bub = '{default: 0};
      reset_i = 1'b1;
      drive(bub, 1'b0);
      dir_q.push_back(mk(1, 0, 1, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF));
      dir_q.push_back(mk(1, 0, 1, 3'b000, 32'h103, 32'h0, 0, 32'h80FFFF7F));
      dir_q.push_back(mk(1, 0, 1, 3'b100, 32'h103, 32'h0, 0, 32'h80FFFF7F));
      dir_q.push_back(mk(0, 1, 0, 3'b001, 32'h102, 32'h1234ABCD, 0, 32'h0));
      dir_q.push_back(mk(1, 0, 1, 3'b010, 32'h10, 32'h0, 3, 32'h13579BDF));
      dir_q.push_back(mk(0, 0, 1, 3'b000, 32'h55, 32'h0, 0, 32'h0));
      dir_q.push_back(mk(1, 0, 1, 3'b001, 32'h101, 32'h0, 0, 32'h0));
      dir_q.push_back(mk(1, 0, 1, 3'b010, 32'h200, 32'h0, 9, 32'h0));
      dir_q.push_back(mk(1, 1, 1, 3'b000, 32'h7, 32'hA5, 1, 32'h0));

      #2;
      chk("rst_req", 32'(ma_if.dmem_req_o), 32'd0);
      chk("rst_stall", 32'(ma_if.stall_m_o), 32'd0);
      chk("rst_reg_write", 32'(ma_if.reg_write_m_o), 32'd0);
      chk("rst_timeout", 32'(ma_if.timeout_o), 32'd0);
      chk("rst_err", 32'(ma_if.access_err_o), 32'd0);
      chk("rst_be", 32'(ma_if.dmem_be_o), 32'd0);
      chk("rst_alu", ma_if.alu_result_m_o, 32'd0);

      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
      #3;
      exp_q.push_back(model(bub));
      mon_en = 1;

      issued = 0; guard = 0;
      total = dir_q.size() + NRAND + 10;
      while (issued < total && guard < 20000) begin
         @(negedge clk_i);
         #2;
         guard++;
         if (!ma_if.stall_m_o) begin
            flush = 0;
            if (dir_q.size() != 0) cur = dir_q.pop_front();
            else if (issued < total - 10) begin
               cur = rand_ins();
               flush = $urandom_range(0, 7) == 0;
            end else cur = bub;
            drive(cur, flush);
            mi = cur;
            if (flush) mi.valid = 0;
            exp_q.push_back(model(mi));
            issued++;
         end else begin
            drive(rand_ins(), 1'b1);
         end
      end
      if (guard >= 20000) begin
         n_chk++; n_err++;
         $display("FAIL drive_budget: got %0d issued expected %0d", issued, total);
      end

      @(negedge clk_i);
      #3;
      mon_en = 0;
      man_ready = 0;
      drive(mk(1, 0, 1, 3'b010, 32'h20, 32'h0, 0, 32'h0), 1'b0);
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      chk("rw_req", 32'(ma_if.dmem_req_o), 32'd1);
      chk("rw_stall", 32'(ma_if.stall_m_o), 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      chk("rw_wait_stall", 32'(ma_if.stall_m_o), 32'd1);
      chk("timeout_hold", 32'(ma_if.timeout_o), 32'(to_exp));
      reset_i = 1'b1;
      #1;
      chk("rmid_req", 32'(ma_if.dmem_req_o), 32'd0);
      chk("rmid_stall", 32'(ma_if.stall_m_o), 32'd0);
      chk("rmid_timeout", 32'(ma_if.timeout_o), 32'd0);
      chk("rmid_reg_write", 32'(ma_if.reg_write_m_o), 32'd0);
      chk("rmid_be", 32'(ma_if.dmem_be_o), 32'd0);
      drive(bub, 1'b0);
      @(negedge clk_i);
      reset_i = 1'b0;
      drive(mk(1, 0, 1, 3'b010, 32'h100, 32'h0, 0, 32'h0), 1'b0);
      man_ready = 1;
      man_rdata = 32'hCAFEF00D;
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      chk("post_rst_stall", 32'(ma_if.stall_m_o), 32'd0);
      chk("post_rst_req", 32'(ma_if.dmem_req_o), 32'd1);
      chk("post_rst_rdata", ma_if.read_data_m_o, 32'hCAFEF00D);
      chk("post_rst_reg_write", 32'(ma_if.reg_write_m_o), 32'd1);
      chk("post_rst_timeout", 32'(ma_if.timeout_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
